alu_operand_seq: RTL
====================

# alu_operand_seq

Front-end sequencer that drives the 4-bit ALU/segment-display datapath from the board. It debounces three push buttons and walks the user through entering operand A, operand B and the 3-bit opcode from the 4 slide switches. It then holds the ALU enable for a fixed settle window and captures the returned result and flags into registers for display. It sits between the board I/O and the ALU: it produces the ALU's operand/opcode/enable inputs and consumes its result outputs.

## Interface
- DEBOUNCE_CYCLES, 20, consecutive stable cycles required before a button level is accepted (≥2)
- SETTLE_CYCLES, 2, cycles alu_en is held before result capture (≥1)
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- sw  in  4  slide switches (operand value, or opcode in sw[2:0])
- btn  in  3  raw buttons: [0] next, [1] clear, [2] rerun
- alu_result  in  4  result from ALU
- alu_flags  in  4  {CF,ZF,SF,OF} from ALU
- a, b  out  4 each  registered operands to ALU
- op  out  3  registered opcode to ALU
- alu_en  out  1  ALU enable
- result_q  out  4  captured result
- flags_q  out  4  captured {CF,ZF,SF,OF}
- stage  out  3  current state code
- done  out  1  high while a valid captured result is shown
- op_count  out  8  completed executions, wraps

## Operation
- Reset values: a=b=0, op=0, alu_en=0, result_q=0, flags_q=0, done=0, op_count=0, stage=S_A, debouncers stable-low.
- Each button: 2-flop synchronizer. Stable level changes after DEBOUNCE_CYCLES consecutive synced cycles differ from it. One-cycle pulse on stable rising edge only. Held button yields exactly one pulse; release generates none.
- States (stage codes): S_A=0, S_B=1, S_OP=2, S_EXEC=3, S_SHOW=4.
  - S_A: next → a<=sw, go S_B.
  - S_B: next → b<=sw, go S_OP.
  - S_OP: next → op<=sw[2:0], go S_EXEC, settle counter<=0.
  - S_EXEC: alu_en=1. Count SETTLE_CYCLES cycles. On the last one, result_q<=alu_result, flags_q<=alu_flags, op_count<=op_count+1 (mod 256), go S_SHOW. All buttons ignored.
  - S_SHOW: done=1. next → clear done, go S_A; a, b, op retained until overwritten. rerun → go S_EXEC with same a, b, op.
- clear pulse in any state: a=b=op=0, result_q=flags_q=0, done=0, alu_en=0, go S_A; op_count kept. Clear pulse has priority over next or rerun in the same cycle and aborts S_EXEC without capture.
- next and rerun in the same cycle in S_SHOW: next wins.
- rerun outside S_SHOW and next in S_EXEC/S_SHOW-except-as-above: ignored.
- alu_en=0 in every state except S_EXEC.

## Timing
- Raw button rise sampled at edge 0 and held → pulse high in cycle 2+DEBOUNCE_CYCLES, exactly one cycle.
- State transition and operand latch take effect on the edge where the pulse is high. New values are visible the next cycle.
- alu_en is high for exactly SETTLE_CYCLES cycles. Capture samples alu_result/alu_flags at the final enabled edge. done rises the cycle after alu_en falls.
- rst asserted anytime (including mid-S_EXEC or mid-debounce) forces reset values immediately. The first pulse after release requires a full fresh debounce window.

## Structure
- Package alu_seq_pkg: state enum/codes, button index constants (BTN_NEXT=0, BTN_CLR=1, BTN_RERUN=2), flag bit positions (CF=3, ZF=2, SF=1, OF=0).
- Sub-module btn_debounce (synchronizer, counter, stable level, rise pulse), instantiated three times, parameterized by DEBOUNCE_CYCLES.
- Top holds FSM, settle counter, operand/result registers, op_count.

## Test plan
Use DEBOUNCE_CYCLES=4 and SETTLE_CYCLES=2. The bench models the ALU as add when op=0.
- Basic add: sw=3 + next, sw=5 + next, sw=0 + next → alu_en high exactly 2 cycles; then result_q=8, flags_q from model (OF=1, SF=1), done=1, stage=4, op_count=1.
- Glitch rejection: btn[0] high for 3 cycles then low → no pulse, stage unchanged. Held for 50 cycles → one advance only.
- Priority: clear and next pulses in the same cycle in S_B → stage=0, a=0, b=0.
- Rerun and wrap: in S_SHOW, rerun → second execution with identical a, b, op. Preload op_count=255 via 255 reruns → wraps to 0.
- Reset mid-exec: assert rst during the first alu_en cycle → all outputs at reset values next cycle, no capture, op_count=0.
- Clear mid-exec: clear pulse during S_EXEC → alu_en drops, result_q=0, done=0, op_count unchanged.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operand sequencer: FSM state codes,
// button indices and ALU flag bit positions.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_SHOW = 3'd4
  } state_t;

  localparam int BTN_NEXT  = 0;
  localparam int BTN_CLR   = 1;
  localparam int BTN_RERUN = 2;

  localparam int FLAG_CF = 3;
  localparam int FLAG_ZF = 2;
  localparam int FLAG_SF = 1;
  localparam int FLAG_OF = 0;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter and a
// registered one-cycle pulse on each accepted rising edge.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_r;
  logic          sync2_r;
  logic          stable_r;
  logic          stable_d_r;
  logic          pulse_r;
  logic [CW-1:0] cnt_r;

  // two-flop synchronizer for the raw button
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= btn;
      sync2_r <= sync1_r;
    end
  end

  // stable level flips only after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r    <= {CW{1'b0}};
      stable_r <= 1'b0;
    end else if (sync2_r == stable_r) begin
      cnt_r    <= {CW{1'b0}};
    end else if (cnt_r == CNT_LAST) begin
      cnt_r    <= {CW{1'b0}};
      stable_r <= sync2_r;
    end else begin
      cnt_r    <= cnt_r + CW'(1);
    end
  end

  // registered rising-edge detect on the stable level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_d_r <= 1'b0;
      pulse_r    <= 1'b0;
    end else begin
      stable_d_r <= stable_r;
      pulse_r    <= stable_r & ~stable_d_r;
    end
  end

  assign pulse = pulse_r;

endmodule

// File: rtl/alu_operand_seq.sv
// Board front-end for the 4-bit ALU: collects A, B and opcode from the switches,
// runs the ALU for a fixed settle window and latches result/flags for display.
module alu_operand_seq #(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int SETTLE_CYCLES   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw,
  input  logic [2:0] btn,
  input  logic [3:0] alu_result,
  input  logic [3:0] alu_flags,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic [2:0] op,
  output logic       alu_en,
  output logic [3:0] result_q,
  output logic [3:0] flags_q,
  output logic [2:0] stage,
  output logic       done,
  output logic [7:0] op_count
);

  import alu_seq_pkg::*;

  localparam int SW_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SW_W-1:0] SETTLE_LAST = SW_W'(SETTLE_CYCLES - 1);

  logic [2:0]      pulse_s;
  logic            next_p_s;
  logic            clr_p_s;
  logic            rerun_p_s;

  state_t          state_r;
  state_t          state_nx_s;
  logic [SW_W-1:0] settle_r;
  logic [3:0]      a_r;
  logic [3:0]      b_r;
  logic [2:0]      op_r;
  logic [3:0]      result_r;
  logic [3:0]      flags_r;
  logic [7:0]      op_count_r;
  logic            alu_en_r;
  logic            done_r;

  logic            load_a_s;
  logic            load_b_s;
  logic            load_op_s;
  logic            capture_s;
  logic            clear_s;

  for (genvar i = 0; i < 3; i++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn[i]),
      .pulse (pulse_s[i])
    );
  end

  assign next_p_s  = pulse_s[BTN_NEXT];
  assign clr_p_s   = pulse_s[BTN_CLR];
  assign rerun_p_s = pulse_s[BTN_RERUN];

  // next-state and datapath strobes; clear overrides everything
  always_comb begin
    state_nx_s = state_r;
    load_a_s   = 1'b0;
    load_b_s   = 1'b0;
    load_op_s  = 1'b0;
    capture_s  = 1'b0;
    clear_s    = 1'b0;
    if (clr_p_s) begin
      clear_s    = 1'b1;
      state_nx_s = S_A;
    end else begin
      case (state_r)
        S_A: begin
          if (next_p_s) begin
            load_a_s   = 1'b1;
            state_nx_s = S_B;
          end else begin
            state_nx_s = S_A;
          end
        end
        S_B: begin
          if (next_p_s) begin
            load_b_s   = 1'b1;
            state_nx_s = S_OP;
          end else begin
            state_nx_s = S_B;
          end
        end
        S_OP: begin
          if (next_p_s) begin
            load_op_s  = 1'b1;
            state_nx_s = S_EXEC;
          end else begin
            state_nx_s = S_OP;
          end
        end
        S_EXEC: begin
          if (settle_r == SETTLE_LAST) begin
            capture_s  = 1'b1;
            state_nx_s = S_SHOW;
          end else begin
            state_nx_s = S_EXEC;
          end
        end
        S_SHOW: begin
          if (next_p_s) begin
            state_nx_s = S_A;
          end else if (rerun_p_s) begin
            state_nx_s = S_EXEC;
          end else begin
            state_nx_s = S_SHOW;
          end
        end
        default: begin
          state_nx_s = S_A;
        end
      endcase
    end
  end

  // state register with registered enable/done decoded from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= S_A;
      alu_en_r <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_nx_s;
      alu_en_r <= (state_nx_s == S_EXEC);
      done_r   <= (state_nx_s == S_SHOW);
    end
  end

  // settle counter restarts on every entry into S_EXEC
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settle_r <= {SW_W{1'b0}};
    end else if ((state_r == S_EXEC) && (state_nx_s == S_EXEC)) begin
      settle_r <= settle_r + SW_W'(1);
    end else begin
      settle_r <= {SW_W{1'b0}};
    end
  end

  // operand, result and execution-count registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r        <= 4'd0;
      b_r        <= 4'd0;
      op_r       <= 3'd0;
      result_r   <= 4'd0;
      flags_r    <= 4'd0;
      op_count_r <= 8'd0;
    end else if (clear_s) begin
      a_r        <= 4'd0;
      b_r        <= 4'd0;
      op_r       <= 3'd0;
      result_r   <= 4'd0;
      flags_r    <= 4'd0;
    end else begin
      if (load_a_s)  a_r  <= sw;
      if (load_b_s)  b_r  <= sw;
      if (load_op_s) op_r <= sw[2:0];
      if (capture_s) begin
        result_r   <= alu_result;
        flags_r    <= alu_flags;
        op_count_r <= op_count_r + 8'd1;
      end
    end
  end

  assign a        = a_r;
  assign b        = b_r;
  assign op       = op_r;
  assign alu_en   = alu_en_r;
  assign result_q = result_r;
  assign flags_q  = flags_r;
  assign stage    = state_r;
  assign done     = done_r;
  assign op_count = op_count_r;

endmodule
